// File: rtl/comm_pkg.sv
// Shared types for the host-side command UART: frame sequencer and receiver states.
package comm_pkg;

  typedef enum logic [2:0] {IDLE, CMD, DATAH, DATAL, DONE} frame_state_e;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  localparam int FRAME_BYTES = 3;

endpackage

// File: rtl/uart_tx.sv
// Byte-wide 8N1 transmitter; tx_done marks the last clock of the stop bit so a
// back-to-back trmt in that cycle starts the next start bit with no idle gap.
module uart_tx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [8:0]    shift_q, shift_d;
  logic          busy_q, busy_d;
  logic          tx_q, tx_d;

  always_comb begin
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    busy_d     = busy_q;
    tx_d       = tx_q;
    tx_done    = busy_q && (baud_cnt_q == '0) && (bit_cnt_q == '0);

    if (busy_q) begin
      if (baud_cnt_q == '0) begin
        baud_cnt_d = BAUD_LAST;
        if (bit_cnt_q == '0) begin
          busy_d = 1'b0;
          tx_d   = 1'b1;
        end else begin
          tx_d      = shift_q[0];
          shift_d   = {1'b1, shift_q[8:1]};
          bit_cnt_d = bit_cnt_q - 4'd1;
        end
      end else begin
        baud_cnt_d = baud_cnt_q - CW'(1);
      end
    end

    // shift holds data then stop; the start bit goes straight onto the line
    if (trmt && (!busy_q || tx_done)) begin
      busy_d     = 1'b1;
      tx_d       = 1'b0;
      baud_cnt_d = BAUD_LAST;
      bit_cnt_d  = 4'd9;
      shift_d    = {1'b1, tx_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '1;
      busy_q     <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      busy_q     <= busy_d;
      tx_q       <= tx_d;
    end
  end

  assign TX = tx_q;

endmodule

// File: rtl/comm_master_uart.sv
// Host-side link: sends cmd/data-high/data-low frames over TX and captures
// single-byte responses from RX.
//  state | meaning
//  IDLE  | waiting for send_cmd; cmd byte launched on acceptance
//  CMD   | cmd byte on the line
//  DATAH | data[15:8] on the line
//  DATAL | data[7:0] on the line
//  DONE  | frame complete, frm_snt set
module comm_master_uart import comm_pkg::*; #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  input  logic        send_cmd,
  input  logic        clr_resp_rdy,
  output logic        frm_snt,
  output logic        resp_rdy,
  output logic [7:0]  resp
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] RX_FULL = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] RX_HALF = CW'(BAUD_DIV / 2 - 1);

  frame_state_e state_q, state_d;
  logic [15:0]  data_q, data_d;
  logic         frm_snt_q, frm_snt_d;
  logic         trmt, tx_done, accept;
  logic [7:0]   tx_byte;

  rx_state_e    rx_state_q, rx_state_d;
  logic         rx_meta_q, rx_sync_q, rx_last_q;
  logic [CW-1:0] rx_baud_q, rx_baud_d;
  logic [2:0]   rx_bit_q, rx_bit_d;
  logic [7:0]   rx_shift_q, rx_shift_d;
  logic [7:0]   resp_q, resp_d;
  logic         resp_rdy_q, resp_rdy_d;
  logic         rx_set;

  uart_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk     (clk),
    .rst     (rst),
    .trmt    (trmt),
    .tx_data (tx_byte),
    .TX      (TX),
    .tx_done (tx_done)
  );

  // cmd goes straight into the transmitter's shift register, which holds it
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    frm_snt_d = frm_snt_q;
    trmt      = 1'b0;
    accept    = 1'b0;
    tx_byte   = cmd;
    case (state_q)
      IDLE: if (send_cmd) begin
        accept    = 1'b1;
        data_d    = data;
        frm_snt_d = 1'b0;
        trmt      = 1'b1;
        state_d   = CMD;
      end
      CMD: if (tx_done) begin
        trmt    = 1'b1;
        tx_byte = data_q[15:8];
        state_d = DATAH;
      end
      DATAH: if (tx_done) begin
        trmt    = 1'b1;
        tx_byte = data_q[7:0];
        state_d = DATAL;
      end
      DATAL: if (tx_done) begin
        frm_snt_d = 1'b1;
        state_d   = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    resp_d     = resp_q;
    rx_set     = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (rx_last_q && !rx_sync_q) begin
        rx_state_d = RX_START;
        rx_baud_d  = RX_HALF;
      end
      RX_START: begin
        if (rx_baud_q == '0) begin
          rx_baud_d  = RX_FULL;
          rx_bit_d   = 3'd7;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else rx_baud_d = rx_baud_q - CW'(1);
      end
      RX_DATA: begin
        if (rx_baud_q == '0) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_baud_d  = RX_FULL;
          rx_bit_d   = rx_bit_q - 3'd1;
          if (rx_bit_q == '0) rx_state_d = RX_STOP;
        end else rx_baud_d = rx_baud_q - CW'(1);
      end
      RX_STOP: begin
        if (rx_baud_q == '0) begin
          rx_state_d = RX_IDLE;
          if (rx_sync_q) begin
            resp_d = rx_shift_q;
            rx_set = 1'b1;
          end
        end else rx_baud_d = rx_baud_q - CW'(1);
      end
      default: rx_state_d = RX_IDLE;
    endcase

    resp_rdy_d = resp_rdy_q;
    if (clr_resp_rdy || accept) resp_rdy_d = 1'b0;
    if (rx_set) resp_rdy_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      data_q     <= '0;
      frm_snt_q  <= 1'b0;
      rx_state_q <= RX_IDLE;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_last_q  <= 1'b1;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      resp_q     <= '0;
      resp_rdy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      frm_snt_q  <= frm_snt_d;
      rx_state_q <= rx_state_d;
      rx_meta_q  <= RX;
      rx_sync_q  <= rx_meta_q;
      rx_last_q  <= rx_sync_q;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      resp_q     <= resp_d;
      resp_rdy_q <= resp_rdy_d;
    end
  end

  assign frm_snt  = frm_snt_q;
  assign resp_rdy = resp_rdy_q;
  assign resp     = resp_q;

endmodule

// File: tb/tb_comm_master_uart.sv
// Bench for comm_master_uart: waveform-level model of the transmitted frame,
// loopback decoder on TX, and an RX driver with expected response tracking.
module tb_comm_master_uart;

  localparam int B = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RX = 1'b1;
  logic        send_cmd = 1'b0;
  logic        clr_resp_rdy = 1'b0;
  logic [7:0]  cmd = '0;
  logic [15:0] data = '0;
  logic        TX, frm_snt, resp_rdy;
  logic [7:0]  resp;

  comm_master_uart #(.BAUD_DIV(B)) dut (
    .clk          (clk),
    .rst          (rst),
    .RX           (RX),
    .TX           (TX),
    .cmd          (cmd),
    .data         (data),
    .send_cmd     (send_cmd),
    .clr_resp_rdy (clr_resp_rdy),
    .frm_snt      (frm_snt),
    .resp_rdy     (resp_rdy),
    .resp         (resp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // 30 line bits of a frame, index 0 = cmd start bit
  function automatic logic [29:0] frame_bits(input logic [7:0] c, input logic [15:0] d);
    logic [29:0] r;
    logic [7:0]  by [3];
    by[0] = c; by[1] = d[15:8]; by[2] = d[7:0];
    for (int b = 0; b < 3; b++) begin
      r[b*10] = 1'b0;
      for (int i = 0; i < 8; i++) r[b*10+1+i] = by[b][i];
      r[b*10+9] = 1'b1;
    end
    return r;
  endfunction

  // reference model
  logic        m_busy = 1'b0, m_frm = 1'b0, m_rdy = 1'b0, m_tx = 1'b1;
  logic [7:0]  m_resp = '0;
  int          m_n = 0;
  logic [29:0] m_bits = '1;
  int          rx_ev = 0, rx_ev_seen = 0;
  logic [7:0]  rx_ev_byte = '0;
  logic        rx_ev_valid = 1'b0;
  logic        rx_active = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_frm = 1'b0; m_rdy = 1'b0; m_resp = '0; m_tx = 1'b1;
      rx_ev_seen = rx_ev;
    end else begin
      if (m_busy) begin
        m_n++;
        if (m_n == 30*B) begin
          m_busy = 1'b0; m_frm = 1'b1; m_tx = 1'b1;
        end else m_tx = m_bits[m_n/B];
      end else if (send_cmd) begin
        m_busy = 1'b1; m_n = 0; m_bits = frame_bits(cmd, data);
        m_frm = 1'b0; m_rdy = 1'b0; m_tx = m_bits[0];
      end
      if (clr_resp_rdy) m_rdy = 1'b0;
      if (rx_ev != rx_ev_seen) begin
        rx_ev_seen = rx_ev;
        if (rx_ev_valid) begin m_resp = rx_ev_byte; m_rdy = 1'b1; end
      end
    end
  end

  always @(negedge clk) begin
    chk("tx_line", TX, m_tx);
    chk("frm_snt", frm_snt, m_frm);
    if (!rx_active) begin
      chk("resp", resp, m_resp);
      chk("resp_rdy", resp_rdy, m_rdy);
    end
  end

  // loopback decoder on TX
  logic [7:0] dec_q[$];
  logic       dec_on = 1'b0;
  int         dec_t = 0;
  logic [9:0] dec_sh = '0;
  always @(negedge clk) begin
    if (rst) dec_on = 1'b0;
    else if (!dec_on) begin
      if (TX === 1'b0) begin dec_on = 1'b1; dec_t = 0; end
    end else begin
      dec_t++;
      if (dec_t >= B/2 && (dec_t - B/2) % B == 0) begin
        dec_sh[(dec_t - B/2) / B] = TX;
        if ((dec_t - B/2) / B == 9) begin
          dec_on = 1'b0;
          if (dec_sh[0] == 1'b0 && dec_sh[9] == 1'b1) dec_q.push_back(dec_sh[8:1]);
        end
      end
    end
  end

  task automatic send(input logic [7:0] c, input logic [15:0] d, output int t_acc);
    @(posedge clk); #1;
    cmd = c; data = d; send_cmd = 1'b1;
    @(posedge clk); #1;
    t_acc = cyc;
    send_cmd = 1'b0;
    cmd = 8'($urandom); data = 16'($urandom);
  endtask

  task automatic wait_frame(input int t_acc, input logic [7:0] c, input logic [15:0] d, input int base);
    int t = 0;
    int lat;
    logic [7:0] e [3];
    e[0] = c; e[1] = d[15:8]; e[2] = d[7:0];
    while (frm_snt !== 1'b1 && t < 40*B) begin @(negedge clk); t++; end
    checks++;
    if (frm_snt !== 1'b1) begin
      errors++;
      $display("FAIL frame_timeout frm_snt=%b after %0d cycles", frm_snt, t);
    end else begin
      lat = cyc - t_acc;
      if (lat < 30*B - 1 || lat > 30*B + 1) begin
        errors++;
        $display("FAIL frm_latency actual=%0d required=%0d+-1", lat, 30*B);
      end
    end
    repeat (4) @(posedge clk); #1;
    chk("frame_len", dec_q.size(), base + 3);
    for (int i = 0; i < 3; i++)
      if (base + i < dec_q.size()) chk("frame_byte", dec_q[base+i], e[i]);
  endtask

  task automatic rx_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    rx_active = 1'b1;
    for (int i = 0; i < 9; i++) begin
      RX = f[i];
      repeat (B) @(posedge clk); #1;
    end
    RX = stop;
    repeat (B/2) @(posedge clk); #1;
    chk("rx_rdy_early", resp_rdy, m_rdy);
    repeat (4) @(posedge clk); #1;
    chk("rx_rdy_mid", resp_rdy, stop ? 1'b1 : m_rdy);
    repeat (B - B/2 - 4) @(posedge clk); #1;
    RX = 1'b1;
    chk("rx_resp", resp, stop ? b : m_resp);
    rx_ev_byte = b; rx_ev_valid = stop; rx_ev++;
    @(posedge clk); #1;
    rx_active = 1'b0;
  endtask

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int t, base, g;
    logic [7:0]  c, rb;
    logic [15:0] d;
    logic        st;

    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    repeat (10*B) @(posedge clk); #1;
    chk("idle_tx", TX, 1'b1);
    chk("idle_frm", frm_snt, 1'b0);
    chk("idle_rdy", resp_rdy, 1'b0);
    chk("idle_resp", resp, 8'h00);

    base = dec_q.size();
    send(8'h05, 16'h01FF, t);
    wait_frame(t, 8'h05, 16'h01FF, base);
    chk("lit_b0", dec_q[base], 8'h05);
    chk("lit_b1", dec_q[base+1], 8'h01);
    chk("lit_b2", dec_q[base+2], 8'hFF);
    chk("lit_frm", frm_snt, 1'b1);

    rx_byte(8'hA5, 1'b1);
    chk("lit_resp_a5", resp, 8'hA5);
    chk("lit_rdy_a5", resp_rdy, 1'b1);
    clr_resp_rdy = 1'b1;
    @(posedge clk); #1;
    clr_resp_rdy = 1'b0;
    chk("lit_rdy_clr", resp_rdy, 1'b0);

    base = dec_q.size();
    d = 16'($urandom);
    send(8'h06, d, t);
    repeat (12*B) @(posedge clk); #1;
    cmd = 8'h08; data = ~d; send_cmd = 1'b1;
    @(posedge clk); #1;
    send_cmd = 1'b0;
    wait_frame(t, 8'h06, d, base);
    repeat (15*B) @(posedge clk); #1;
    chk("no_second_frame", dec_q.size(), base + 3);

    rx_byte(8'h3C, 1'b0);
    chk("lit_ferr_resp", resp, 8'hA5);
    chk("lit_ferr_rdy", resp_rdy, 1'b0);
    rx_byte(8'h5A, 1'b1);
    chk("lit_resp_5a", resp, 8'h5A);

    g = $urandom_range(1, B/2 - 4);
    RX = 1'b0;
    repeat (g) @(posedge clk); #1;
    RX = 1'b1;
    repeat (3*B) @(posedge clk); #1;
    chk("glitch_resp", resp, 8'h5A);

    send(8'($urandom), 16'($urandom), t);
    repeat (14*B) @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_tx", TX, 1'b1);
    chk("rst_rdy", resp_rdy, 1'b0);
    chk("rst_resp", resp, 8'h00);
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    repeat (2*B) @(posedge clk); #1;
    base = dec_q.size();
    c = 8'($urandom); d = 16'($urandom);
    send(c, d, t);
    wait_frame(t, c, d, base);

    for (int k = 0; k < 6; k++) begin
      c = 8'($urandom); d = 16'($urandom);
      rb = 8'($urandom); st = ($urandom_range(0, 3) != 0);
      g = $urandom_range(0, 5*B);
      base = dec_q.size();
      fork
        begin
          int ta;
          send(c, d, ta);
          wait_frame(ta, c, d, base);
        end
        begin
          repeat (g) @(posedge clk); #1;
          rx_byte(rb, st);
        end
      join
      if ($urandom_range(0, 1) == 1) begin
        clr_resp_rdy = 1'b1;
        @(posedge clk); #1;
        clr_resp_rdy = 1'b0;
      end
      repeat ($urandom_range(2*B, 4*B)) @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
